// File: rtl/ipdb_common_clk_gate_ctrl_if.sv
// ipdb_common_clk_gate_ctrl_if: control, activity and gated-clock bundle for the clock-gate controller.
interface ipdb_common_clk_gate_ctrl_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
);
    logic             gate_en_i;
    logic             scen_i;
    logic [N_CH-1:0]  busy_i;
    logic [N_CH-1:0]  force_on_i;
    logic [CNT_W-1:0] idle_cycles_i;
    logic [N_CH-1:0]  clk_o;
    logic [N_CH-1:0]  en_o;
    logic             active_o;

    modport master (
        output gate_en_i, scen_i, busy_i, force_on_i, idle_cycles_i,
        input  clk_o, en_o, active_o
    );

    modport slave (
        input  gate_en_i, scen_i, busy_i, force_on_i, idle_cycles_i,
        output clk_o, en_o, active_o
    );
endinterface

// File: rtl/ipdb_common_clk_gate_ctrl.sv
// ipdb_common_clk_gate_ctrl: per-channel idle-gating FSM driving latch-based glitch-free clock gates.
module ipdb_common_clk_gate_ctrl #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    ipdb_common_clk_gate_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {OFF, ON, HOLD} state_e;

    state_e           state_q [N_CH];
    state_e           state_d [N_CH];
    logic [CNT_W-1:0] cnt_q   [N_CH];
    logic [CNT_W-1:0] cnt_d   [N_CH];
    logic [N_CH-1:0]  want;
    logic [N_CH-1:0]  en_q;
    logic [N_CH-1:0]  en_d;
    logic [N_CH-1:0]  lat_q;

    assign want = bus.busy_i | bus.force_on_i | {N_CH{~bus.gate_en_i}};

    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            state_d[c] = state_q[c];
            cnt_d[c]   = cnt_q[c];
            case (state_q[c])
                OFF:  state_d[c] = want[c] ? ON : OFF;
                ON: if (!want[c]) begin
                    state_d[c] = (bus.idle_cycles_i == '0) ? OFF : HOLD;
                    cnt_d[c]   = (bus.idle_cycles_i == '0) ? '0 : bus.idle_cycles_i - 1'b1;
                end
                HOLD: if (want[c]) begin
                    state_d[c] = ON;
                end else if (cnt_q[c] == '0) begin
                    state_d[c] = OFF;
                end else begin
                    cnt_d[c] = cnt_q[c] - 1'b1;
                end
                default: state_d[c] = OFF;
            endcase
            en_d[c] = (state_d[c] != OFF);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int c = 0; c < N_CH; c++) begin
                state_q[c] <= OFF;
                cnt_q[c]   <= '0;
            end
            en_q <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
            end
            en_q <= en_d;
        end
    end

    // Latch is opaque during the high phase, so an async reset or scen change never truncates a pulse.
    always_latch begin
        if (!clk_i) lat_q <= en_q | {N_CH{bus.scen_i}};
    end

    assign bus.clk_o    = lat_q & {N_CH{clk_i}};
    assign bus.en_o     = en_q;
    assign bus.active_o = |en_q;
endmodule

// File: tb/tb_ipdb_common_clk_gate_ctrl.sv
// tb_ipdb_common_clk_gate_ctrl: directed scenarios plus a queue-based scoreboard for the clock-gate controller.
module tb_ipdb_common_clk_gate_ctrl;
    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    ipdb_common_clk_gate_ctrl_if #(.N_CH(N), .CNT_W(W)) bus ();
    ipdb_common_clk_gate_ctrl #(.N_CH(N), .CNT_W(W)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    always #5 clk = ~clk;

    // Reference model: en after each edge, with a remaining-cycles counter for the hold-off
    logic [N-1:0] m_en = '0;
    logic [N-1:0] m_on = '0;
    int           m_left [N];
    logic [N-1:0] exp_q [$];
    logic         sb_on = 1'b0;
    logic [N-1:0] e;
    int           dut_cnt [N];
    int           exp_cnt [N];
    logic [N-1:0] clk_prev = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_en = '0;
            m_on = '0;
            for (int c = 0; c < N; c++) m_left[c] = 0;
        end else begin
            for (int c = 0; c < N; c++) begin
                if (bus.busy_i[c] || bus.force_on_i[c] || !bus.gate_en_i) begin
                    m_on[c] = 1'b1;
                    m_en[c] = 1'b1;
                end else if (m_on[c]) begin
                    m_on[c]   = 1'b0;
                    m_left[c] = int'(bus.idle_cycles_i);
                    m_en[c]   = (m_left[c] != 0);
                end else if (m_left[c] != 0) begin
                    m_left[c] = m_left[c] - 1;
                    m_en[c]   = (m_left[c] != 0);
                end
            end
            if (sb_on) exp_q.push_back(m_en);
        end
    end

    always @(posedge clk) begin
        #1;
        if (sb_on && exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            for (int c = 0; c < N; c++) exp_cnt[c] += int'(e[c]);
            checks++;
            if (bus.clk_o !== e) begin
                errors++;
                $display("FAIL sb_clk_o t=%0t: got %b exp %b", $time, bus.clk_o, e);
            end
            checks++;
            if (bus.en_o !== m_en) begin
                errors++;
                $display("FAIL sb_en_o t=%0t: got %b exp %b", $time, bus.en_o, m_en);
            end
        end
    end

    always @(bus.clk_o) begin
        for (int c = 0; c < N; c++)
            if (sb_on && bus.clk_o[c] === 1'b1 && clk_prev[c] !== 1'b1) dut_cnt[c]++;
        clk_prev = bus.clk_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.gate_en_i = 1'b1; bus.scen_i = 1'b0; bus.busy_i = '0; bus.force_on_i = '0; bus.idle_cycles_i = '0;
        repeat (3) tick();
        checks++; if (bus.en_o !== '0) begin errors++; $display("FAIL rst_en: got %b exp 0000", bus.en_o); end
        checks++; if (bus.clk_o !== '0) begin errors++; $display("FAIL rst_clk: got %b exp 0000", bus.clk_o); end
        checks++; if (bus.active_o !== 1'b0) begin errors++; $display("FAIL rst_active: got %b exp 0", bus.active_o); end
        @(negedge clk); rst = 1'b0;
        repeat (2) tick();
        checks++; if (bus.en_o !== '0 || bus.clk_o !== '0) begin
            errors++; $display("FAIL post_rst: en %b clk %b exp 0000", bus.en_o, bus.clk_o); end
    endtask

    task automatic test_wake();
        @(negedge clk); bus.busy_i = 4'b0001;
        tick();
        checks++; if (bus.en_o !== 4'b0001) begin errors++; $display("FAIL wake_en: got %b exp 0001", bus.en_o); end
        checks++; if (bus.clk_o !== 4'b0000) begin errors++; $display("FAIL wake_clk_k: got %b exp 0000", bus.clk_o); end
        checks++; if (bus.active_o !== 1'b1) begin errors++; $display("FAIL wake_active: got %b exp 1", bus.active_o); end
        tick();
        checks++; if (bus.clk_o !== 4'b0001) begin errors++; $display("FAIL wake_clk_k1: got %b exp 0001", bus.clk_o); end
    endtask

    task automatic test_hold();
        @(negedge clk); bus.idle_cycles_i = 8'd5; bus.busy_i = 4'b0011;
        repeat (2) tick();
        @(negedge clk); bus.busy_i = 4'b0001;
        tick();
        checks++; if (bus.en_o[1] !== 1'b1 || bus.clk_o[1] !== 1'b1) begin
            errors++; $display("FAIL hold_k: en %b clk %b exp 1 1", bus.en_o[1], bus.clk_o[1]); end
        @(negedge clk); bus.idle_cycles_i = 8'd1;
        for (int j = 1; j <= 7; j++) begin
            tick();
            checks++; if (bus.clk_o[1] !== (j <= 5)) begin
                errors++; $display("FAIL hold_clk j=%0d: got %b exp %b", j, bus.clk_o[1], (j <= 5)); end
            checks++; if (bus.en_o[1] !== (j < 5)) begin
                errors++; $display("FAIL hold_en j=%0d: got %b exp %b", j, bus.en_o[1], (j < 5)); end
        end
    endtask

    task automatic test_idle_zero();
        @(negedge clk); bus.idle_cycles_i = '0; bus.busy_i = 4'b0101;
        repeat (2) tick();
        @(negedge clk); bus.busy_i = 4'b0001;
        tick();
        checks++; if (bus.en_o[2] !== 1'b0 || bus.clk_o[2] !== 1'b1) begin
            errors++; $display("FAIL idle0_k: en %b clk %b exp 0 1", bus.en_o[2], bus.clk_o[2]); end
        for (int j = 1; j <= 3; j++) begin
            tick();
            checks++; if (bus.clk_o[2] !== 1'b0) begin
                errors++; $display("FAIL idle0_clk j=%0d: got %b exp 0", j, bus.clk_o[2]); end
        end
    endtask

    task automatic test_retrigger();
        @(negedge clk); bus.idle_cycles_i = 8'd5; bus.busy_i = 4'b0101;
        repeat (2) tick();
        @(negedge clk); bus.busy_i = 4'b0001;
        repeat (2) tick();
        @(negedge clk); bus.busy_i = 4'b0101;
        for (int j = 0; j < 6; j++) begin
            tick();
            checks++; if (bus.clk_o[2] !== 1'b1 || bus.en_o[2] !== 1'b1) begin
                errors++; $display("FAIL retrig j=%0d: clk %b en %b exp 1 1", j, bus.clk_o[2], bus.en_o[2]); end
        end
        @(negedge clk); bus.idle_cycles_i = 8'd1; bus.busy_i = 4'b0001;
        tick();
        checks++; if (bus.en_o[2] !== 1'b1) begin errors++; $display("FAIL retrig_on_k: en %b exp 1", bus.en_o[2]); end
        tick();
        checks++; if (bus.clk_o[2] !== 1'b1 || bus.en_o[2] !== 1'b0) begin
            errors++; $display("FAIL retrig_on_k1: clk %b en %b exp 1 0", bus.clk_o[2], bus.en_o[2]); end
        tick();
        checks++; if (bus.clk_o[2] !== 1'b0) begin errors++; $display("FAIL retrig_on_k2: clk %b exp 0", bus.clk_o[2]); end
    endtask

    task automatic test_override();
        @(negedge clk); bus.busy_i = '0; bus.force_on_i = '0; bus.idle_cycles_i = '0;
        repeat (2) tick();
        checks++; if (bus.en_o !== '0) begin errors++; $display("FAIL ovr_off: en %b exp 0000", bus.en_o); end
        @(negedge clk); bus.gate_en_i = 1'b0;
        tick();
        checks++; if (bus.en_o !== 4'b1111) begin errors++; $display("FAIL ovr_gate_en: en %b exp 1111", bus.en_o); end
        tick();
        checks++; if (bus.clk_o !== 4'b1111) begin errors++; $display("FAIL ovr_gate_clk: clk %b exp 1111", bus.clk_o); end
        @(negedge clk); bus.gate_en_i = 1'b1;
        tick();
        checks++; if (bus.en_o !== '0) begin errors++; $display("FAIL ovr_regate_en: en %b exp 0000", bus.en_o); end
        tick();
        checks++; if (bus.clk_o !== '0) begin errors++; $display("FAIL ovr_regate_clk: clk %b exp 0000", bus.clk_o); end
        @(negedge clk); bus.scen_i = 1'b1;
        tick();
        checks++; if (bus.clk_o !== 4'b1111 || bus.en_o !== '0) begin
            errors++; $display("FAIL scan_hi: clk %b en %b exp 1111 0000", bus.clk_o, bus.en_o); end
        @(negedge clk); #1;
        checks++; if (bus.clk_o !== '0) begin errors++; $display("FAIL scan_lo: clk %b exp 0000", bus.clk_o); end
        tick();
        bus.scen_i = 1'b0;
        #1;
        checks++; if (bus.clk_o !== 4'b1111) begin errors++; $display("FAIL scan_drop_mid: clk %b exp 1111", bus.clk_o); end
        tick();
        checks++; if (bus.clk_o !== '0) begin errors++; $display("FAIL scan_off: clk %b exp 0000", bus.clk_o); end
        bus.scen_i = 1'b1;
        #1;
        checks++; if (bus.clk_o !== '0) begin errors++; $display("FAIL scan_rise_mid: clk %b exp 0000", bus.clk_o); end
        tick();
        checks++; if (bus.clk_o !== 4'b1111) begin errors++; $display("FAIL scan_next: clk %b exp 1111", bus.clk_o); end
        @(negedge clk); bus.scen_i = 1'b0;
        tick();
        checks++; if (bus.clk_o !== '0) begin errors++; $display("FAIL scan_end: clk %b exp 0000", bus.clk_o); end
    endtask

    task automatic test_async_reset();
        @(negedge clk); bus.busy_i = 4'b0001;
        repeat (2) tick();
        checks++; if (bus.clk_o[0] !== 1'b1) begin errors++; $display("FAIL arst_pre: clk %b exp 1", bus.clk_o[0]); end
        rst = 1'b1;
        #1;
        checks++; if (bus.en_o !== '0 || bus.active_o !== 1'b0) begin
            errors++; $display("FAIL arst_en: en %b active %b exp 0000 0", bus.en_o, bus.active_o); end
        checks++; if (bus.clk_o[0] !== 1'b1) begin errors++; $display("FAIL arst_pulse: clk %b exp 1", bus.clk_o[0]); end
        @(negedge clk); #1;
        checks++; if (bus.clk_o !== '0) begin errors++; $display("FAIL arst_low: clk %b exp 0000", bus.clk_o); end
        rst = 1'b0; bus.busy_i = '0;
        tick();
        checks++; if (bus.clk_o !== '0 || bus.en_o !== '0) begin
            errors++; $display("FAIL arst_after: clk %b en %b exp 0000 0000", bus.clk_o, bus.en_o); end
    endtask

    task automatic test_independence();
        @(negedge clk); bus.busy_i = '0; bus.force_on_i = '0; bus.idle_cycles_i = 8'd3;
        repeat (2) tick();
        #1;
        for (int c = 0; c < N; c++) begin dut_cnt[c] = 0; exp_cnt[c] = 0; end
        exp_q.delete();
        exp_q.push_back(m_en);
        sb_on = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) bus.busy_i = N'($urandom);
            bus.force_on_i = ($urandom_range(0, 9) == 0) ? N'($urandom) : '0;
        end
        @(negedge clk); bus.busy_i = '0; bus.force_on_i = '0;
        repeat (8) tick();
        #1;
        for (int c = 0; c < N; c++) begin
            checks++;
            if (dut_cnt[c] != exp_cnt[c]) begin
                errors++; $display("FAIL edge_count ch%0d: got %0d exp %0d", c, dut_cnt[c], exp_cnt[c]);
            end
        end
        sb_on = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_wake();
        test_hold();
        test_idle_zero();
        test_retrigger();
        test_override();
        test_async_reset();
        test_independence();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ipdb_common_clk_gate_ctrl.md
Name: ipdb_common_clk_gate_ctrl

Overview:
- Multi-channel, glitch-free clock-gating controller with automatic idle gating.
- Each channel runs a small state machine driven by its activity request. The channel clock opens one cycle after activity is seen, and closes a programmable number of cycles after activity ends.
- Each channel output is a latch-based gate: a negative-level latch followed by an AND.
- The block sits between the free-running SAR ADC core clock and the per-subblock clock domains (sequencer, SAR logic, digital filter, register file).

Parameters:
- N_CH, 4: number of gated clock channels (1..16).
- CNT_W, 8: width of the idle hold-off counter and of idle_cycles_i.

Ports:
- clk_i, input, 1: free-running clock; all state is on its rising edge.
- rst_i, input, 1: asynchronous, active-high reset.
- gate_en_i, input, 1: global auto-gating enable. 0 forces every channel open.
- scen_i, input, 1: scan enable. Combinationally forces every gate open.
- busy_i, input, N_CH: per-channel activity request.
- force_on_i, input, N_CH: per-channel software force-open.
- idle_cycles_i, input, CNT_W: hold-off length in cycles, shared by all channels.
- clk_o, output, N_CH: gated clocks.
- en_o, output, N_CH: registered gate enable per channel.
- active_o, output, 1: OR of en_o.

Behaviour:
- Reset values: state OFF, en_o=0, active_o=0, counters 0, clk_o low.
- Reset is asynchronous. Assertion mid-operation closes enables immediately, but clk_o stays glitch-free: the latch is opaque while clk_i is high, so a running high pulse completes.
- Per channel c, define want[c] = busy_i[c] | force_on_i[c] | ~gate_en_i.
- States are sampled at the clk_i rising edge.
  - OFF, en=0: if want[c], go to ON.
  - ON, en=1: if want[c], stay in ON.
    - Else if idle_cycles_i==0, go to OFF.
    - Else go to HOLD and load cnt = idle_cycles_i-1. idle_cycles_i is captured here; later changes do not affect the hold in progress.
  - HOLD, en=1: if want[c], go to ON (the count is abandoned).
    - Else if cnt==0, go to OFF.
    - Else decrement cnt.
- en_o[c] is 1 exactly in ON and HOLD; it is a registered output.
- Gate cell per channel:
  - Latch transparent while clk_i=0, with data input en_o[c] | scen_i.
  - clk_o[c] = latched value AND clk_i.
  - No combinational path from busy_i to clk_o.
- Wake latency: want sampled at edge k (channel in OFF) gives en_o=1 after edge k. The first clk_o rising edge is at edge k+1.
- Close timing: want low sampled at edge k (channel in ON) means clk_o still pulses on edges k+1..k+idle_cycles_i. No pulse occurs from edge k+idle_cycles_i+1 onward.
- With idle_cycles_i=0, no pulse occurs after edge k.
- A want pulse that re-asserts in HOLD yields a continuous clock with no missing edge.
- scen_i=1 makes clk_o[c] follow clk_i from the next low phase onward, regardless of state. State and en_o keep updating normally underneath.
- Channels are fully independent. Simultaneous events on different channels need no arbitration.
- Counter wrap is impossible: the counter only decrements from a loaded value and stops at 0.
- idle_cycles_i = 2^CNT_W-1 is legal and gives the maximum hold.

Test Plan:
- Reset and wake: assert rst_i, then release, with busy_i=0 → clk_o all low, en_o=0. Set busy_i[0]=1 sampled at edge 10 → en_o[0]=1 after edge 10, first clk_o[0] rise at edge 11, other channels stay low.
- Idle hold-off: idle_cycles_i=5, busy_i[1] drops, sampled at edge 20 → clk_o[1] pulses on edges 21..25, none from edge 26; en_o[1] falls after edge 25.
- Idle zero and re-wake: idle_cycles_i=0, busy_i[2] drops, sampled at edge 30 → no clk_o[2] pulse after edge 30.
- Re-trigger in HOLD: idle_cycles_i=5, busy_i[2] re-asserts during HOLD → clock continuous, no missing edge, state returns to ON.
- Global and scan override: gate_en_i=0 with busy_i=0 → all en_o=1 one edge later and all clocks run. gate_en_i=1 with scen_i=1 → clk_o equals clk_i while en_o=0. Check glitch-freedom by toggling scen_i mid-high-phase.
- Async reset mid-pulse: assert rst_i while clk_i=1 and clk_o[0]=1 → clk_o[0] completes the high pulse, then stays low; en_o=0 immediately.
- Independence: random busy_i/force_on_i on all N_CH=4 channels with idle_cycles_i=3. A scoreboard model checks the exact clk_o edge counts per channel.
